// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the branch resolve unit: condition codes,
// FSM states and the program labels used as branch targets.
package branch_resolve_unit_pkg;

  localparam int COND_W = 3;

  typedef enum logic [COND_W-1:0] {
    EQ  = 3'd0,
    NE  = 3'd1,
    LT  = 3'd2,
    GE  = 3'd3,
    LTU = 3'd4,
    GEU = 3'd5
  } br_cond_e;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  // Program labels of the reference program, as byte addresses.
  localparam int unsigned MAIN    = 4;
  localparam int unsigned LOOP    = 16;
  localparam int unsigned SUMA    = 56;
  localparam int unsigned SUMAAUX = 80;
  localparam int unsigned DONE    = 112;
  localparam int unsigned EXIT    = 128;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Decode/fetch-side bundle of the branch resolve unit. The master drives branch
// requests and stall; the slave (the unit) returns PC and redirect status.
interface branch_resolve_unit_if
  import branch_resolve_unit_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int CNT_W  = 16
);

  logic              stall;
  logic              br_valid;
  logic              br_ready;
  logic [COND_W-1:0] br_cond;
  logic              op2_sel;
  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;
  logic [DATA_W-1:0] imm;
  logic [PC_W-1:0]   target;
  logic [PC_W-1:0]   pc;
  logic              taken;
  logic              flush;
  logic [CNT_W-1:0]  taken_count;

  modport master (
    output stall, br_valid, br_cond, op2_sel, rs1_val, rs2_val, imm, target,
    input  br_ready, pc, taken, flush, taken_count
  );

  modport slave (
    input  stall, br_valid, br_cond, op2_sel, rs1_val, rs2_val, imm, target,
    output br_ready, pc, taken, flush, taken_count
  );

endinterface

// File: rtl/branch_resolve_unit_compare.sv
// Combinational branch condition evaluation: signed and unsigned compares of
// two DATA_W operands. Reserved condition codes never take.
module branch_compare
  import branch_resolve_unit_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [COND_W-1:0] cond,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  output logic              take
);

  logic signed [DATA_W-1:0] op1_s;
  logic signed [DATA_W-1:0] op2_s;

  assign op1_s = $signed(op1);
  assign op2_s = $signed(op2);

  always_comb begin
    take = 1'b0;
    case (cond)
      EQ:      take = (op1 == op2);
      NE:      take = (op1 != op2);
      LT:      take = (op1_s < op2_s);
      GE:      take = (op1_s >= op2_s);
      LTU:     take = (op1 < op2);
      GEU:     take = (op1 >= op2);
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Fetch PC owner and conditional branch resolver. A taken branch redirects the
// PC one cycle after acceptance and then holds flush high for FLUSH_CYCLES.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int PC_W         = 8,
  parameter int PC_STEP      = 4,
  parameter int RESET_PC     = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  branch_resolve_unit_if.slave bus
);

  localparam logic [PC_W-1:0] PC_INC     = PC_W'(PC_STEP);
  localparam logic [PC_W-1:0] PC_RST     = PC_W'(RESET_PC);
  localparam logic [3:0]      FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Stage 0: operand select, compare and acceptance (combinational)
  logic [DATA_W-1:0] op2_p0;
  logic              take_p0;
  logic              accept_p0;
  logic              ready_p0;

  // Stage 1: registered PC, FSM and status
  state_e            state_p1, state_d;
  logic [3:0]        fcnt_p1, fcnt_d;
  logic [PC_W-1:0]   pc_p1, pc_d;
  logic              taken_p1, taken_d;
  logic [CNT_W-1:0]  cnt_p1, cnt_d;

  assign op2_p0    = bus.op2_sel ? bus.imm : bus.rs2_val;
  assign ready_p0  = (state_p1 == IDLE) && !bus.stall;
  assign accept_p0 = bus.br_valid && ready_p0;

  branch_compare #(
    .DATA_W (DATA_W)
  ) u_compare (
    .cond (bus.br_cond),
    .op1  (bus.rs1_val),
    .op2  (op2_p0),
    .take (take_p0)
  );

  always_comb begin
    state_d = state_p1;
    fcnt_d  = fcnt_p1;
    pc_d    = pc_p1;
    taken_d = 1'b0;
    cnt_d   = cnt_p1;
    case (state_p1)
      IDLE: begin
        if (accept_p0 && take_p0) begin
          pc_d    = bus.target;
          taken_d = 1'b1;
          cnt_d   = sat_inc(cnt_p1);
          state_d = FLUSH;
          fcnt_d  = FLUSH_INIT;
        end else if (!bus.stall) begin
          pc_d = pc_p1 + PC_INC;
        end
      end
      FLUSH: begin
        if (!bus.stall) begin
          pc_d = pc_p1 + PC_INC;
        end
        // The flush window is time-based, so the countdown ignores stall.
        if (fcnt_p1 == 4'd0) begin
          state_d = IDLE;
          fcnt_d  = 4'd0;
        end else begin
          fcnt_d = fcnt_p1 - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        fcnt_d  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p1 <= IDLE;
      fcnt_p1  <= 4'd0;
      pc_p1    <= PC_RST;
      taken_p1 <= 1'b0;
      cnt_p1   <= '0;
    end else begin
      state_p1 <= state_d;
      fcnt_p1  <= fcnt_d;
      pc_p1    <= pc_d;
      taken_p1 <= taken_d;
      cnt_p1   <= cnt_d;
    end
  end

  assign bus.br_ready    = ready_p0;
  assign bus.pc          = pc_p1;
  assign bus.taken       = taken_p1;
  assign bus.flush       = (state_p1 == FLUSH);
  assign bus.taken_count = cnt_p1;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed-vector bench for branch_resolve_unit with a queue-based scoreboard:
// the driver pushes hand-computed expectations, the monitor pops and compares.
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  typedef struct {
    logic       rst_n;
    logic       stall;
    logic       vld;
    logic [2:0] cond;
    logic       sel;
    logic [7:0] rs1;
    logic [7:0] rs2;
    logic [7:0] imm;
    logic [7:0] tgt;
    logic       rdy;
    logic [7:0] pc;
    logic       tk;
    logic       fl;
    logic [1:0] cnt;
  } vec_t;

  typedef struct {
    int         row;
    logic       rdy;
    logic [7:0] pc;
    logic       tk;
    logic       fl;
    logic [1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  exp_t exp_q[$];

  always #5 clk = ~clk;

  branch_resolve_unit_if #(.DATA_W(8), .PC_W(8), .CNT_W(2)) bus ();

  branch_resolve_unit #(
    .DATA_W       (8),
    .PC_W         (8),
    .PC_STEP      (4),
    .RESET_PC     (4),
    .FLUSH_CYCLES (2),
    .CNT_W        (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic add(input logic r, input logic st, input logic v, input logic [2:0] c,
                     input logic s, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] im, input logic [7:0] t, input logic rdy,
                     input logic [7:0] pc, input logic tk, input logic fl,
                     input logic [1:0] cnt);
    vec_t x;
    x.rst_n = r; x.stall = st; x.vld = v; x.cond = c; x.sel = s;
    x.rs1 = a; x.rs2 = b; x.imm = im; x.tgt = t;
    x.rdy = rdy; x.pc = pc; x.tk = tk; x.fl = fl; x.cnt = cnt;
    vecs.push_back(x);
  endtask

  task automatic idle(input logic rdy, input logic [7:0] pc, input logic tk,
                      input logic fl, input logic [1:0] cnt);
    add(1, 0, 0, 3'd0, 0, 8'h00, 8'h00, 8'h00, 8'h00, rdy, pc, tk, fl, cnt);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, req);
    end
  endtask

  task automatic drive_idle();
    bus.stall = 0; bus.br_valid = 0; bus.br_cond = 3'd0; bus.op2_sel = 0;
    bus.rs1_val = 8'h00; bus.rs2_val = 8'h00; bus.imm = 8'h00; bus.target = 8'h00;
  endtask

  initial begin
    // rows: rst stall vld cond sel rs1 rs2 imm tgt | rdy pc taken flush count
    add(0, 0, 0, 3'd0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 8'd4, 0, 0, 2'd0);
    idle(1, 8'd8, 0, 0, 2'd0);
    idle(1, 8'd12, 0, 0, 2'd0);
    idle(1, 8'd16, 0, 0, 2'd0);
    add(1, 0, 1, LT, 1, 8'd3, 8'd0, 8'd5, 8'd56, 1, 8'd56, 1, 1, 2'd1);
    add(0, 0, 0, 3'd0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'd4, 0, 0, 2'd0);
    idle(1, 8'd8, 0, 0, 2'd0);
    add(1, 0, 1, LT, 1, 8'd3, 8'd0, 8'd5, 8'd16, 1, 8'd16, 1, 1, 2'd1);
    idle(0, 8'd20, 0, 1, 2'd1);
    idle(0, 8'd24, 0, 0, 2'd1);
    idle(1, 8'd28, 0, 0, 2'd1);
    add(1, 0, 1, LT, 0, 8'hFF, 8'h01, 8'h00, 8'd56, 1, 8'd56, 1, 1, 2'd2);
    idle(0, 8'd60, 0, 1, 2'd2);
    idle(0, 8'd64, 0, 0, 2'd2);
    add(1, 0, 1, LTU, 0, 8'hFF, 8'h01, 8'h00, 8'd56, 1, 8'd68, 0, 0, 2'd2);
    add(1, 0, 1, EQ, 0, 8'd5, 8'd5, 8'd0, 8'd16, 1, 8'd16, 1, 1, 2'd3);
    add(1, 0, 1, EQ, 0, 8'd5, 8'd5, 8'd0, 8'd112, 0, 8'd20, 0, 1, 2'd3);
    add(1, 1, 1, EQ, 0, 8'd5, 8'd5, 8'd0, 8'd112, 0, 8'd20, 0, 0, 2'd3);
    add(1, 1, 1, EQ, 0, 8'd5, 8'd5, 8'd0, 8'd112, 0, 8'd20, 0, 0, 2'd3);
    add(1, 0, 1, EQ, 0, 8'd5, 8'd5, 8'd0, 8'd112, 1, 8'd112, 1, 1, 2'd3);
    idle(0, 8'd116, 0, 1, 2'd3);
    idle(0, 8'd120, 0, 0, 2'd3);
    add(1, 0, 1, GEU, 0, 8'h40, 8'h40, 8'h00, 8'd128, 1, 8'd128, 1, 1, 2'd3);
    idle(0, 8'd132, 0, 1, 2'd3);
    idle(0, 8'd136, 0, 0, 2'd3);
    add(1, 0, 1, NE, 0, 8'd1, 8'd2, 8'd0, 8'd252, 1, 8'd252, 1, 1, 2'd3);
    idle(0, 8'd0, 0, 1, 2'd3);
    idle(0, 8'd4, 0, 0, 2'd3);
    add(1, 0, 1, GE, 1, 8'h7F, 8'h00, 8'h80, 8'd248, 1, 8'd248, 1, 1, 2'd3);
    idle(0, 8'd252, 0, 1, 2'd3);
    idle(0, 8'd0, 0, 0, 2'd3);
    idle(1, 8'd4, 0, 0, 2'd3);
    add(1, 0, 1, 3'd7, 0, 8'd0, 8'd0, 8'd0, 8'd56, 1, 8'd8, 0, 0, 2'd3);
    add(1, 0, 1, 3'd6, 0, 8'd3, 8'd3, 8'd0, 8'd56, 1, 8'd12, 0, 0, 2'd3);
    add(1, 0, 1, GE, 1, 8'h80, 8'h80, 8'h7F, 8'd56, 1, 8'd16, 0, 0, 2'd3);
    add(1, 0, 1, LTU, 0, 8'h01, 8'hFF, 8'h00, 8'd80, 1, 8'd80, 1, 1, 2'd3);
    idle(0, 8'd84, 0, 1, 2'd3);
    idle(0, 8'd88, 0, 0, 2'd3);
    add(1, 0, 1, NE, 0, 8'd9, 8'd9, 8'd0, 8'd56, 1, 8'd92, 0, 0, 2'd3);
    add(1, 0, 1, EQ, 0, 8'd9, 8'd8, 8'd0, 8'd56, 1, 8'd96, 0, 0, 2'd3);
    add(1, 0, 1, EQ, 0, 8'd0, 8'd0, 8'd0, 8'd96, 1, 8'd96, 1, 1, 2'd3);
    idle(0, 8'd100, 0, 1, 2'd3);
    idle(0, 8'd104, 0, 0, 2'd3);
    idle(1, 8'd108, 0, 0, 2'd3);

    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      exp_t e;
      @(negedge clk);
      rst_n        = vecs[i].rst_n;
      bus.stall    = vecs[i].stall;
      bus.br_valid = vecs[i].vld;
      bus.br_cond  = vecs[i].cond;
      bus.op2_sel  = vecs[i].sel;
      bus.rs1_val  = vecs[i].rs1;
      bus.rs2_val  = vecs[i].rs2;
      bus.imm      = vecs[i].imm;
      bus.target   = vecs[i].tgt;
      e.row = i; e.rdy = vecs[i].rdy; e.pc = vecs[i].pc;
      e.tk = vecs[i].tk; e.fl = vecs[i].fl; e.cnt = vecs[i].cnt;
      exp_q.push_back(e);
    end

    @(negedge clk);
    rst_n = 1'b1;
    drive_idle();
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    #20;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    exp_t e;
    logic rdy_s;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e     = exp_q[0];
        rdy_s = bus.br_ready;
        @(posedge clk);
        #1;
        chk("br_ready", e.row, 32'(rdy_s), 32'(e.rdy));
        chk("pc", e.row, 32'(bus.pc), 32'(e.pc));
        chk("taken", e.row, 32'(bus.taken), 32'(e.tk));
        chk("flush", e.row, 32'(bus.flush), 32'(e.fl));
        chk("taken_count", e.row, 32'(bus.taken_count), 32'(e.cnt));
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit, expected completion");
    $fatal(1, "timeout");
  end

endmodule
